// File: rtl/xillybus_pack_8to32.sv
// Packs the 8-bit host write stream little-endian into 32-bit words, buffers them
// in a FIFO for the 32-bit host read stream, and flushes a partial word on close.
//
// state  | meaning
// IDLE   | writer never opened since reset
// ACTIVE | writer open, bytes are being packed
// FLUSH  | writer closed with a partial word held, waiting for FIFO room
// CLOSED | writer closed, nothing pending; EOF once the FIFO drains
module xillybus_pack_8to32 #(
    parameter int          FIFO_AW  = 9,
    parameter logic [7:0]  PAD_BYTE = 8'h00
) (
    input  logic               bus_clk,
    input  logic               bus_rst,
    input  logic               w8_wren,
    input  logic [7:0]         w8_data,
    output logic               w8_full,
    input  logic               w8_open,
    input  logic               r32_rden,
    output logic [31:0]        r32_data,
    output logic               r32_empty,
    output logic               r32_eof,
    input  logic               r32_open,
    output logic               overflow,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int               DEPTH     = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_CNT = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, CLOSED} state_t;

    state_t             state, state_nxt;
    logic [1:0]         byte_idx, byte_idx_nxt;
    logic [23:0]        packer, packer_nxt;
    logic [FIFO_AW:0]   count;
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]        mem [DEPTH];
    logic               full, empty, pop, push, accept;
    logic [31:0]        push_word, flush_word;

    assign full       = (count == DEPTH_CNT);
    assign empty      = (count == '0);
    assign pop        = r32_rden & ~empty;
    assign accept     = (state == ACTIVE) & w8_open & w8_wren & ~full;
    assign w8_full    = full;
    assign r32_empty  = empty;
    assign r32_eof    = (state == CLOSED) & empty & r32_open;
    assign fifo_level = count;

    // Lanes at or above byte_idx were never written in this word; they get PAD_BYTE.
    always_comb begin
        flush_word = {4{PAD_BYTE}};
        for (int k = 0; k < 3; k++) begin
            if (k < int'(byte_idx))
                flush_word[8*k +: 8] = packer[8*k +: 8];
        end
    end

    always_comb begin
        state_nxt    = state;
        byte_idx_nxt = byte_idx;
        packer_nxt   = packer;
        push         = 1'b0;
        push_word    = flush_word;
        case (state)
            IDLE, CLOSED: begin
                if (w8_open) begin
                    state_nxt    = ACTIVE;
                    byte_idx_nxt = 2'd0;
                    packer_nxt   = '0;
                end
            end
            ACTIVE: begin
                if (!w8_open) begin
                    state_nxt = (byte_idx != 2'd0) ? FLUSH : CLOSED;
                end else if (accept) begin
                    case (byte_idx)
                        2'd0: packer_nxt[7:0]   = w8_data;
                        2'd1: packer_nxt[15:8]  = w8_data;
                        2'd2: packer_nxt[23:16] = w8_data;
                        default: begin
                            push       = 1'b1;
                            push_word  = {w8_data, packer};
                            packer_nxt = '0;
                        end
                    endcase
                    byte_idx_nxt = byte_idx + 2'd1;
                end
            end
            FLUSH: begin
                // A same-cycle pop frees a slot, so a full FIFO does not stall the flush then.
                if (!full || pop) begin
                    push         = 1'b1;
                    byte_idx_nxt = 2'd0;
                    packer_nxt   = '0;
                    state_nxt    = CLOSED;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            state    <= IDLE;
            byte_idx <= 2'd0;
            packer   <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            r32_data <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            byte_idx <= byte_idx_nxt;
            packer   <= packer_nxt;
            if (w8_wren && full)
                overflow <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                r32_data <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge bus_clk) begin
        if (push)
            mem[wr_ptr] <= push_word;
    end

endmodule
